// File: rtl/ls323_seq.sv
// ls323_seq: command sequencer for one sn74ls323 8-bit shift/storage register on a shared I/O bus.
// Latency: busy for clear 1, load 2, shift N (1..8) cycles, +1 with read-back; done in the next idle cycle.
// Backpressure: cmd_ready is high only while idle; cmd_valid during busy cycles is ignored, nothing is queued.
module ls323_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_cnt,
  input  logic       cmd_fill,
  input  logic       cmd_rd,
  input  logic [7:0] din,
  input  logic [7:0] qio,
  output logic       bus_oe,
  output logic       s1,
  output logic       s0,
  output logic       g1,
  output logic       g2,
  output logic       sl,
  output logic       sr,
  output logic       rclr,
  output logic [7:0] dout,
  output logic       done,
  output logic       dout_valid
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_TURN  = 3'd4,
    ST_READ  = 3'd5
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic       fill_q;
  logic       rd_q;
  logic [7:0] din_q;
  logic [2:0] rem_q, rem_nxt;

  logic       accept;
  logic [1:0] op_eff;
  logic       fill_eff;

  logic       done_nxt, dv_nxt;
  logic       ready_nxt, oe_nxt, s1_nxt, s0_nxt, g_nxt, sl_nxt, sr_nxt, rclr_nxt;

  // The load data reaches the register through the external driver while bus_oe is high;
  // the captured copy is kept only so the accepted command is fully visible in state.
  logic       unused_din;

  assign accept     = cmd_valid & cmd_ready;
  // On the accept edge the command latches are not yet updated, so the pin decode
  // for the first busy cycle takes the command fields straight from the inputs.
  assign op_eff     = accept ? cmd_op : op_q;
  assign fill_eff   = accept ? cmd_fill : fill_q;
  assign unused_din = ^din_q;

  // State register and shift down-counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
      rem_q <= 3'd0;
    end else begin
      state <= state_nxt;
      rem_q <= rem_nxt;
    end
  end

  // Capture the command fields when a command is accepted.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q   <= OP_CLR;
      fill_q <= 1'b0;
      rd_q   <= 1'b0;
      din_q  <= 8'h00;
    end else if (accept) begin
      op_q   <= cmd_op;
      fill_q <= cmd_fill;
      rd_q   <= cmd_rd;
      din_q  <= din;
    end
  end

  // Next-state logic, counter update and completion pulses.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    done_nxt  = 1'b0;
    dv_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLR:  state_nxt = ST_CLR;
            OP_LOAD: state_nxt = ST_LOAD;
            default: begin
              // Remaining-cycles count minus one; cnt=0 wraps to 7, giving 8 shifts.
              state_nxt = ST_SHIFT;
              rem_nxt   = cmd_cnt - 3'd1;
            end
          endcase
        end
      end
      ST_CLR: begin
        state_nxt = rd_q ? ST_READ : ST_IDLE;
        done_nxt  = ~rd_q;
      end
      ST_LOAD: begin
        // Always pass through TURN so the driver is off a full cycle before any read.
        state_nxt = ST_TURN;
      end
      ST_TURN: begin
        state_nxt = rd_q ? ST_READ : ST_IDLE;
        done_nxt  = ~rd_q;
      end
      ST_SHIFT: begin
        if (rem_q == 3'd0) begin
          state_nxt = rd_q ? ST_READ : ST_IDLE;
          done_nxt  = ~rd_q;
        end else begin
          rem_nxt = rem_q - 3'd1;
        end
      end
      ST_READ: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
        dv_nxt    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pin values for the state being entered; registered below so every output is a flop.
  always_comb begin
    ready_nxt = 1'b0;
    oe_nxt    = 1'b0;
    s1_nxt    = 1'b0;
    s0_nxt    = 1'b0;
    g_nxt     = 1'b1;
    sl_nxt    = 1'b0;
    sr_nxt    = 1'b0;
    rclr_nxt  = 1'b1;
    case (state_nxt)
      ST_IDLE:  ready_nxt = 1'b1;
      ST_CLR:   rclr_nxt  = 1'b0;
      ST_LOAD: begin
        s1_nxt = 1'b1;
        s0_nxt = 1'b1;
        oe_nxt = 1'b1;
      end
      ST_SHIFT: begin
        if (op_eff == OP_SHR) begin
          s0_nxt = 1'b1;
          sr_nxt = fill_eff;
        end else begin
          s1_nxt = 1'b1;
          sl_nxt = fill_eff;
        end
      end
      ST_READ:  g_nxt = 1'b0;
      default:  ready_nxt = 1'b0;
    endcase
  end

  // Output register; reset holds the sn74ls323 in clear and the bus quiet.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cmd_ready  <= 1'b1;
      bus_oe     <= 1'b0;
      s1         <= 1'b0;
      s0         <= 1'b0;
      g1         <= 1'b1;
      g2         <= 1'b1;
      sl         <= 1'b0;
      sr         <= 1'b0;
      rclr       <= 1'b0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      cmd_ready  <= ready_nxt;
      bus_oe     <= oe_nxt;
      s1         <= s1_nxt;
      s0         <= s0_nxt;
      g1         <= g_nxt;
      g2         <= g_nxt;
      sl         <= sl_nxt;
      sr         <= sr_nxt;
      rclr       <= rclr_nxt;
      done       <= done_nxt;
      dout_valid <= dv_nxt;
    end
  end

  // Read-back capture at the edge ending the READ cycle, when the register drives qio.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dout <= 8'h00;
    end else if (state == ST_READ) begin
      dout <= qio;
    end
  end

endmodule

// File: tb/tb_ls323_seq.sv
// tb_ls323_seq: sequencer plus a behavioural sn74ls323 on the shared bus.
// Table vectors, a held-valid alternation run, random commands and a mid-shift reset.
// Expected values come from arithmetic on the command rules, not from the DUT.
`timescale 1ns/1ps
module tb_ls323_seq;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_cnt = 3'd0;
  logic       cmd_fill = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] qio;
  logic       bus_oe, s1, s0, g1, g2, sl, sr, rclr, done, dout_valid;
  logic [7:0] dout;

  always #5 clk = ~clk;

  ls323_seq dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_rd(cmd_rd),
    .din(din), .qio(qio), .bus_oe(bus_oe), .s1(s1), .s0(s0), .g1(g1), .g2(g2),
    .sl(sl), .sr(sr), .rclr(rclr), .dout(dout), .done(done), .dout_valid(dout_valid)
  );

  // Behavioural sn74ls323: synchronous clear, shift right toward QH, shift left toward QA, parallel load.
  logic [7:0] chip_q = 8'h00;
  always @(posedge clk) begin
    if (!rclr) chip_q <= 8'h00;
    else begin
      case ({s1, s0})
        2'b01:   chip_q <= {chip_q[6:0], sr};
        2'b10:   chip_q <= {sl, chip_q[7:1]};
        2'b11:   chip_q <= qio;
        default: chip_q <= chip_q;
      endcase
    end
  end
  // Undriven bus reads as 0xA5 so a mistimed read is visible.
  assign qio = bus_oe ? din : ((!g1 && !g2) ? chip_q : 8'hA5);

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Continuous bus-ownership and pulse-relationship monitor.
  int   viol = 0;
  logic prev_oe = 1'b0;
  logic prev_glow = 1'b0;
  always @(negedge clk) begin
    if (bus_oe && (!g1 || !g2)) viol++;
    if (prev_oe && (!g1 || !g2)) viol++;
    if (prev_glow && bus_oe) viol++;
    if (sr && ({s1, s0} != 2'b01)) viol++;
    if (sl && ({s1, s0} != 2'b10)) viol++;
    if (dout_valid && !done) viol++;
    if (done && !cmd_ready) viol++;
    prev_oe   = bus_oe;
    prev_glow = !g1 || !g2;
  end

  // Reference rules.
  function automatic int nsh(input logic [2:0] c);
    return (c == 3'd0) ? 8 : int'(c);
  endfunction

  function automatic int ref_busy(input logic [1:0] op, input logic [2:0] c, input logic rd);
    int b;
    case (op)
      2'd0:    b = 1;
      2'd3:    b = 2;
      default: b = nsh(c);
    endcase
    return b + (rd ? 1 : 0);
  endfunction

  function automatic logic [7:0] ref_apply(input logic [7:0] q, input logic [1:0] op,
                                           input logic [2:0] c, input logic f, input logic [7:0] d);
    logic [7:0] r;
    r = q;
    case (op)
      2'd0: r = 8'h00;
      2'd3: r = d;
      2'd1: for (int i = 0; i < nsh(c); i++) r = (r << 1) | {7'b0, f};
      default: for (int i = 0; i < nsh(c); i++) r = (r >> 1) | (f ? 8'h80 : 8'h00);
    endcase
    return r;
  endfunction

  typedef struct {
    int         busy;
    logic       dn;
    logic       dv;
    logic [7:0] dq;
    int         oe_c;
    int         sh_good;
    int         sh_bad;
    int         rclr_c;
    int         g_c;
  } res_t;

  // Issue one command from a negedge and observe until the done cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] c, input logic f,
                        input logic rd, input logic [7:0] d, output res_t r);
    int w;
    r = '{0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0};
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    cmd_op = op; cmd_cnt = c; cmd_fill = f; cmd_rd = rd; din = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    while (!cmd_ready && r.busy < 40) begin
      r.busy++;
      if (bus_oe) r.oe_c++;
      if (!rclr) r.rclr_c++;
      if (!g1 || !g2) r.g_c++;
      if ({s1, s0} == 2'b01 || {s1, s0} == 2'b10) begin
        if (op == 2'b01 && {s1, s0} == 2'b01 && sr == f && !sl) r.sh_good++;
        else if (op == 2'b10 && {s1, s0} == 2'b10 && sl == f && !sr) r.sh_good++;
        else r.sh_bad++;
      end
      @(negedge clk);
    end
    if (!cmd_ready) r.busy = -1;
    r.dn = done;
    r.dv = dout_valid;
    r.dq = dout;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic       fill;
    logic       rd;
    logic [7:0] d;
    int         busy;
    logic       dv;
    logic [7:0] dq;
  } vec_t;

  vec_t       vec[10];
  res_t       r;
  logic [7:0] ref_q, ref_dout, mq, mdout, ad;
  logic [1:0] aop;
  logic       afill, ard;
  int         nrdy, macc, nxt, w, ndone;

  initial begin
    // Reset state.
    #2 clr = 1'b0;
    @(negedge clk);
    chk("rst_pins", {s1, s0, g1, g2, bus_oe, sl, sr, rclr, done, dout_valid}, 10'b00_11_0_00_0_0_0);
    chk("rst_dout", dout, 8'h00);
    @(negedge clk);
    clr = 1'b1;
    #1 chk("rst_rclr_held", rclr, 1'b0);
    @(negedge clk);
    chk("rst_rclr_rel", rclr, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_nodone", done, 1'b0);

    // Directed vectors: op, cnt, fill, rd, din, busy cycles, dout_valid, dout.
    vec[0] = '{2'd3, 3'd0, 1'b0, 1'b1, 8'hCA, 3, 1'b1, 8'hCA};
    vec[1] = '{2'd1, 3'd1, 1'b1, 1'b1, 8'h00, 2, 1'b1, 8'h95};
    vec[2] = '{2'd2, 3'd1, 1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h4A};
    vec[3] = '{2'd1, 3'd0, 1'b1, 1'b1, 8'h00, 9, 1'b1, 8'hFF};
    vec[4] = '{2'd0, 3'd5, 1'b1, 1'b1, 8'h00, 2, 1'b1, 8'h00};
    vec[5] = '{2'd3, 3'd0, 1'b0, 1'b0, 8'h3C, 2, 1'b0, 8'h00};
    vec[6] = '{2'd2, 3'd3, 1'b1, 1'b1, 8'h00, 4, 1'b1, 8'hE7};
    vec[7] = '{2'd1, 3'd2, 1'b0, 1'b0, 8'h00, 2, 1'b0, 8'hE7};
    vec[8] = '{2'd2, 3'd7, 1'b0, 1'b1, 8'h00, 8, 1'b1, 8'h01};
    vec[9] = '{2'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h01};
    ref_q = 8'h00;
    ref_dout = 8'h00;
    for (int i = 0; i < 10; i++) begin
      do_cmd(vec[i].op, vec[i].cnt, vec[i].fill, vec[i].rd, vec[i].d, r);
      chk($sformatf("v%0d_busy", i), r.busy, vec[i].busy);
      chk($sformatf("v%0d_done", i), r.dn, 1'b1);
      chk($sformatf("v%0d_dv", i), r.dv, vec[i].dv);
      chk($sformatf("v%0d_dout", i), r.dq, vec[i].dq);
      chk($sformatf("v%0d_oe_cyc", i), r.oe_c, (vec[i].op == 2'd3) ? 1 : 0);
      chk($sformatf("v%0d_shift_cyc", i), r.sh_good,
          (vec[i].op == 2'd1 || vec[i].op == 2'd2) ? nsh(vec[i].cnt) : 0);
      chk($sformatf("v%0d_shift_bad", i), r.sh_bad, 0);
      chk($sformatf("v%0d_rclr_cyc", i), r.rclr_c, (vec[i].op == 2'd0) ? 1 : 0);
      chk($sformatf("v%0d_g_cyc", i), r.g_c, vec[i].rd ? 1 : 0);
      ref_q = ref_apply(ref_q, vec[i].op, vec[i].cnt, vec[i].fill, vec[i].d);
      if (vec[i].rd) ref_dout = ref_q;
    end

    // cmd_valid held high with load / shift-read alternating every cycle.
    nrdy = 0; macc = 0; nxt = 0; mq = ref_q; mdout = ref_dout;
    ad = 8'h00; aop = 2'd3; afill = 1'b0; ard = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t % 2 == 0) begin
        aop = 2'd3; ard = 1'b0; ad = 8'(t * 29 + 7);
      end else begin
        aop = 2'd1; ard = 1'b1; afill = ((t / 2) % 2) == 1;
      end
      cmd_op = aop; cmd_cnt = 3'd1; cmd_fill = afill; cmd_rd = ard; din = ad;
      cmd_valid = 1'b1;
      if (cmd_ready) nrdy++;
      if (t == nxt) begin
        macc++;
        mq = ref_apply(mq, aop, 3'd1, afill, ad);
        if (ard) mdout = mq;
        nxt = t + ref_busy(aop, 3'd1, ard) + 1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("alt_ready", cmd_ready, 1'b1);
    chk("alt_accepts", nrdy, macc);
    chk("alt_dout", dout, mdout);
    ref_q = mq;
    ref_dout = mdout;

    // Random commands against the reference rules.
    for (int k = 0; k < 150; k++) begin
      aop = 2'($urandom_range(0, 3));
      cmd_cnt = 3'($urandom_range(0, 7));
      afill = 1'($urandom_range(0, 1));
      ard = 1'($urandom_range(0, 1));
      ad = 8'($urandom_range(0, 255));
      do_cmd(aop, cmd_cnt, afill, ard, ad, r);
      ref_q = ref_apply(ref_q, aop, cmd_cnt, afill, ad);
      if (ard) ref_dout = ref_q;
      chk($sformatf("r%0d_busy", k), r.busy, ref_busy(aop, cmd_cnt, ard));
      chk($sformatf("r%0d_done", k), r.dn, 1'b1);
      chk($sformatf("r%0d_dv", k), r.dv, ard);
      chk($sformatf("r%0d_dout", k), r.dq, ref_dout);
    end

    // Reset in the middle of an 8-cycle shift.
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    cmd_op = 2'd1; cmd_cnt = 3'd0; cmd_fill = 1'b1; cmd_rd = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_pre_shift", {s1, s0}, 2'b01);
    #2 clr = 1'b0;
    #1 chk("mid_rst_pins", {s1, s0, g1, g2, bus_oe, sl, sr, rclr, done, dout_valid}, 10'b00_11_0_00_0_0_0);
    chk("mid_rst_dout", dout, 8'h00);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1 chk("mid_rclr_held", rclr, 1'b0);
    @(posedge clk);
    #1 chk("mid_rclr_rel", rclr, 1'b1);
    chk("mid_ready", cmd_ready, 1'b1);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || dout_valid) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    do_cmd(2'd3, 3'd0, 1'b0, 1'b1, 8'h5C, r);
    chk("post_rst_busy", r.busy, 3);
    chk("post_rst_dout", r.dq, 8'h5C);

    chk("invariants", viol, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/ls323_seq.md
# ls323_seq

Command sequencer for one sn74ls323 8-bit universal shift/storage register with tri-state I/O. It accepts clear, load, shift-right and shift-left commands over a valid/ready handshake. For each command it drives the register's mode, output-enable, serial-fill and clear pins for the exact number of clocks needed, and optionally reads the register contents back over the shared I/O bus. It owns bus direction, so the external data driver and the register's outputs are never enabled together.

## Interface
- no parameters; widths fixed by the sn74ls323 (8-bit data, 3-bit shift count)
- clk  in  1  system clock; also clocks the sn74ls323
- clr  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle; command accepted on rising clk edge with cmd_valid=1
- cmd_op  in  2  00 clear, 01 shift right, 10 shift left, 11 load
- cmd_cnt  in  3  shift count; 0 means 8; ignored for clear/load
- cmd_fill  in  1  serial fill bit for shifts
- cmd_rd  in  1  read register contents after the operation
- din  in  8  load data; captured at accept
- qio  in  8  sn74ls323 I/O bus as seen by the sequencer
- bus_oe  out  1  enables the external driver of din onto qio
- s1, s0  out  1 each  sn74ls323 mode pins
- g1, g2  out  1 each  sn74ls323 output enables, active low
- sl, sr  out  1 each  sn74ls323 serial inputs
- rclr  out  1  sn74ls323 clear, active low
- dout  out  8  read-back data
- done  out  1  one-cycle completion pulse
- dout_valid  out  1  one-cycle pulse; dout holds new data

## Operation
- All outputs are registered. The sn74ls323 samples them on the clk edge that ends the cycle in which they are held.
- States: IDLE, CLR, LOAD, SHIFT, TURN, READ.
- IDLE: cmd_ready=1, s=00, g1=g2=1, bus_oe=0, rclr=1. On accept, latch op/cnt/fill/rd/din and go to the op state.
- CLR: rclr=0, s=00 for 1 cycle. Next state is READ if rd, else IDLE.
- LOAD: s=11, g1=g2=1, bus_oe=1 for 1 cycle. Next state is TURN.
- TURN: everything quiet (s=00, g high, bus_oe=0) for 1 cycle. Next state is READ if rd, else IDLE.
- SHIFT: s=01 (right, sr=fill) or s=10 (left, sl=fill) for N cycles, N = cnt or 8 if cnt=0. A down-counter tracks the remaining cycles. Next state is READ if rd, else IDLE. No turnaround is needed because bus_oe stays 0.
- READ: s=00, g1=g2=0 for 1 cycle. dout <= qio at the edge ending the cycle. Next state is IDLE.
- sl and sr are 0 outside SHIFT, and the unused serial input is 0 during SHIFT.
- Bit convention: qio[0]=QA, qio[7]=QH.
  - Shift right: q <= {q[6:0], fill}.
  - Shift left: q <= {fill, q[7:1]}.
- Invariants:
  - bus_oe=1 implies g1=g2=1.
  - At least one cycle separates bus_oe falling and g going low, and vice versa. IDLE lasts ≥1 cycle and TURN follows LOAD.
- cmd_valid while cmd_ready=0 is ignored; nothing is queued.
- Reset (clr low, asynchronous): state=IDLE, s=00, g1=g2=1, bus_oe=0, sl=sr=0, rclr=0, dout=0, done=0, dout_valid=0.
  - rclr=0 clears the sn74ls323 too. rclr returns to 1 at the first clk edge after clr releases.
  - Reset mid-command aborts it with no done pulse.

## Timing
- Accept at edge E0. Busy cycles, with cmd_ready low throughout:
  - clear: 1 cycle
  - load: 2 cycles (LOAD, TURN)
  - shift: N cycles
  - each of the above adds 1 cycle if rd
- done is high in the first IDLE cycle after completion, so ready and done are high together.
- dout_valid coincides with done for rd commands. dout is stable until the next read.
- Back-to-back: a new command may be accepted at the edge ending the done cycle.

## Test plan
- Reset: hold clr low mid-SHIFT → all outputs at reset values immediately; after release, rclr=1 after one edge, cmd_ready=1, no done.
- Load 0xCA with rd, sequencer plus sn74ls323 instance → bus_oe high exactly 1 cycle; cmd_ready low 3 cycles; done and dout_valid together; dout=0xCA.
- After 0xCA: shift right cnt=1 fill=1 with rd → dout=0x95. Then shift left cnt=1 fill=0 with rd → dout=0x4A.
- Shift right cnt=0 fill=1 with rd → s=01 for exactly 8 cycles, dout=0xFF. Then clear with rd → rclr low 1 cycle, dout=0x00.
- cmd_valid held continuously with alternating load/read commands → no command accepted while busy; continuous assertion check finds no cycle with bus_oe=1 and g1=g2=0, and no adjacent-cycle bus_oe/g overlap.
- Load without rd → g1/g2 stay high throughout, no dout_valid, done after 2 busy cycles.
